bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the serial pattern-detector path. Accepts WIDTH-bit words over a

---
 rtl/ser_pkg.sv | 10 +
 rtl/bit_serializer_if.sv | 32 +++
 rtl/bit_serializer.sv | 86 ++++++++
 tb/tb_bit_serializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types for the serial pattern-detector path.
// The serializer and the detector both import this package.
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle for bit_serializer.
// The slave modport is the serializer; the master modport is its upstream/downstream side.
interface bit_serializer_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             dout;
   logic             dout_valid;
   logic             last_bit;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output dout,
      output dout_valid,
      output last_bit
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  dout,
      input  dout_valid,
      input  last_bit
   );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: shifts WIDTH-bit words out one bit per clk with zero-gap
// streaming between back-to-back words, a sticky underrun flag and a words-sent counter.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0,
   parameter int   CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   bit_serializer_if.slave      bus,
   output logic                 underrun,
   input  logic                 clr_underrun,
   output logic [CNT_W-1:0]     words_sent
);

   localparam int            CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic             accept;
   logic             word_done;

   // shreg always holds the not-yet-presented bits, so its head is the next bit for dout.
   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign bus.in_ready = !rst && ((state == IDLE) || bus.last_bit);
   assign accept       = bus.in_valid && bus.in_ready;
   assign word_done    = (state == SHIFT) && bus.last_bit;

   // A word accepted on a last_bit cycle loads straight over the finishing one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         shreg          <= '0;
         bus.dout       <= IDLE_BIT;
         bus.dout_valid <= 1'b0;
         bus.last_bit   <= 1'b0;
         underrun       <= 1'b0;
         words_sent     <= '0;
      end else begin
         if (accept) begin
            state          <= SHIFT;
            bit_cnt        <= '0;
            shreg          <= advance(bus.in_data);
            bus.dout       <= head(bus.in_data);
            bus.dout_valid <= 1'b1;
            bus.last_bit   <= 1'b0;
         end else if (state == SHIFT && !bus.last_bit) begin
            bit_cnt        <= bit_cnt + CW'(1);
            shreg          <= advance(shreg);
            bus.dout       <= head(shreg);
            bus.last_bit   <= (bit_cnt == PENULT);
         end else if (word_done) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            bus.dout       <= IDLE_BIT;
            bus.dout_valid <= 1'b0;
            bus.last_bit   <= 1'b0;
         end

         if (word_done) begin
            words_sent <= words_sent + CNT_W'(1);
         end

         // A fresh gap outranks a clear arriving on the same edge.
         if (word_done && !bus.in_valid) begin
            underrun <= 1'b1;
         end else if (clr_underrun) begin
            underrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first (16-bit counter) and LSB-first (2-bit counter) serializers
// driven with identical stimulus and compared each cycle against a bit-queue reference model.
module tb_bit_serializer;

   localparam logic IDLE_B   = 1'b0;
   localparam int   WAIT_MAX = 24;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        undA, undB;
   logic [15:0] wsA;
   logic [1:0]  wsB;

   bit_serializer_if #(.WIDTH(8)) busA ();
   bit_serializer_if #(.WIDTH(8)) busB ();

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_B), .CNT_W(16)) dutA (
      .clk          (clk),
      .rst          (rst),
      .bus          (busA.slave),
      .underrun     (undA),
      .clr_underrun (clr),
      .words_sent   (wsA)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_B), .CNT_W(2)) dutB (
      .clk          (clk),
      .rst          (rst),
      .bus          (busB.slave),
      .underrun     (undB),
      .clr_underrun (clr),
      .words_sent   (wsB)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   fails  = 0;
   bit   qA[$];
   bit   qB[$];
   int   modelWords = 0;
   logic modelUnd   = 1'b0;
   logic expReady;
   logic lastShown;
   logic acceptedFlag = 1'b0;
   int   n;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
      end
   endtask

   // Outputs are sampled mid-cycle; the inputs visible now are the ones the next edge applies.
   always @(negedge clk) begin
      n        = qA.size();
      expReady = !rst && (n <= 1);
      checkOutput("readyA",    32'(busA.in_ready),   32'(expReady));
      checkOutput("readyB",    32'(busB.in_ready),   32'(expReady));
      checkOutput("validA",    32'(busA.dout_valid), 32'(n > 0));
      checkOutput("validB",    32'(busB.dout_valid), 32'(n > 0));
      checkOutput("doutA",     32'(busA.dout),       32'((n > 0) ? qA[0] : IDLE_B));
      checkOutput("doutB",     32'(busB.dout),       32'((n > 0) ? qB[0] : IDLE_B));
      checkOutput("lastA",     32'(busA.last_bit),   32'(n == 1));
      checkOutput("lastB",     32'(busB.last_bit),   32'(n == 1));
      checkOutput("underrunA", 32'(undA),            32'(modelUnd));
      checkOutput("underrunB", 32'(undB),            32'(modelUnd));
      checkOutput("wordsA",    32'(wsA),             32'(modelWords % 65536));
      checkOutput("wordsB",    32'(wsB),             32'(modelWords % 4));

      acceptedFlag = busA.in_valid && expReady;
      if (rst) begin
         qA.delete();
         qB.delete();
         modelWords = 0;
         modelUnd   = 1'b0;
      end else begin
         lastShown = (n == 1);
         if (n > 0) begin
            void'(qA.pop_front());
            void'(qB.pop_front());
         end
         if (lastShown) modelWords++;
         if (clr) modelUnd = 1'b0;
         if (lastShown && !busA.in_valid) modelUnd = 1'b1;
         if (acceptedFlag) begin
            for (int i = 0; i < 8; i++) begin
               qA.push_back(busA.in_data[7-i]);
               qB.push_back(busA.in_data[i]);
            end
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c, input logic r);
      busA.in_valid = v;
      busB.in_valid = v;
      busA.in_data  = d;
      busB.in_data  = d;
      clr           = c;
      rst           = r;
      @(posedge clk);
      #1;
   endtask

   task automatic sendWord(input logic [7:0] d);
      for (int i = 0; i < WAIT_MAX; i++) begin
         applyStimulus(1'b1, d, 1'b0, 1'b0);
         if (acceptedFlag) return;
      end
      checkOutput("sendTimeout", 32'(acceptedFlag), 32'(1));
   endtask

   task automatic idleCycles(input int cnt);
      for (int i = 0; i < cnt; i++) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0);
   endtask

   logic       holding;
   logic [7:0] word;
   logic       r, c;

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      busA.in_valid = 1'b0;
      busB.in_valid = 1'b0;
      busA.in_data  = '0;
      busB.in_data  = '0;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      idleCycles(2);

      $display("[TB] single word 8'hB0, then gap");
      sendWord(8'hB0);
      idleCycles(10);

      $display("[TB] back-to-back 8'h0B, 8'hB0");
      sendWord(8'h0B);
      sendWord(8'hB0);
      idleCycles(10);

      $display("[TB] 8'h0D (LSB-first instance yields 1,0,1,1,0,0,0,0)");
      sendWord(8'h0D);
      idleCycles(10);

      $display("[TB] reset on 4th bit of 8'hFF");
      sendWord(8'hFF);
      idleCycles(3);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      idleCycles(2);
      sendWord(8'hA5);
      idleCycles(10);

      $display("[TB] underrun clear, then clear colliding with a new gap");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      idleCycles(2);
      sendWord(8'h3C);
      idleCycles(7);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      idleCycles(3);

      $display("[TB] five words for counter wrap");
      for (int i = 0; i < 5; i++) sendWord(8'(8'h11 * (i + 1)));
      idleCycles(10);

      $display("[TB] randomized traffic");
      holding = 1'b0;
      word    = '0;
      for (int i = 0; i < 600; i++) begin
         if (!holding && $urandom_range(0, 3) != 0) begin
            holding = 1'b1;
            word    = 8'($urandom);
         end
         r = ($urandom_range(0, 99) == 0);
         c = ($urandom_range(0, 9) == 0);
         applyStimulus(holding, holding ? word : 8'($urandom), c, r);
         if (acceptedFlag) holding = 1'b0;
      end
      idleCycles(12);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
